// File: rtl/clock_pkg.sv
// Shared constants and helpers for the clock hour-formatting path.
package clock_pkg;

  localparam int HOURS_PER_DAY = 24;
  localparam int HALF_DAY      = 12;
  localparam int HOUR24_W      = 5;
  localparam int HOUR12_W      = 4;

  localparam logic AM = 1'b0;
  localparam logic PM = 1'b1;

  // Binary 0-15 to {tens, ones[3:0]} BCD; tens is a single bit since 15 is the ceiling.
  function automatic logic [HOUR12_W:0] bin_to_bcd(input logic [HOUR12_W-1:0] bin);
    logic [HOUR12_W:0] bcd;
    bcd = {1'b0, bin};
    if (bin >= HOUR12_W'(10)) bcd = {1'b1, bin - HOUR12_W'(10)};
    return bcd;
  endfunction

endpackage

// File: rtl/h12_bcd_split.sv
// Combinational 4-bit binary to tens/ones BCD split for the 12-hour display digits.
module h12_bcd_split
  import clock_pkg::*;
(
  input  logic [HOUR12_W-1:0] i_bin,
  output logic                o_tens,
  output logic [3:0]          o_ones
);

  logic [HOUR12_W:0] w_bcd;

  assign w_bcd  = bin_to_bcd(i_bin);
  assign o_tens = w_bcd[HOUR12_W];
  assign o_ones = w_bcd[HOUR12_W-1:0];

endmodule

// File: rtl/h24_to_h12.sv
// Registered 24-hour to 12-hour converter with AM/PM flag and range error.
// Optional BCD digit outputs are enabled by defining H24TOH12_BCD_EN.
module h24_to_h12
  import clock_pkg::*;
#(
  parameter bit MIDNIGHT_12 = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [HOUR24_W-1:0] hour24,
  input  logic                in_valid,
  output logic                nAM_PM,
  output logic [HOUR12_W-1:0] hour12,
  output logic                out_valid,
  output logic                err
`ifdef H24TOH12_BCD_EN
  ,
  output logic                hour12_tens,
  output logic [3:0]          hour12_ones
`endif
);

  localparam logic [HOUR12_W-1:0] MIDNIGHT_HOUR = MIDNIGHT_12 ? HOUR12_W'(HALF_DAY) : '0;

  logic                r_nam_pm;
  logic [HOUR12_W-1:0] r_hour12;
  logic                r_out_valid;
  logic                r_err;

  logic                w_in_range;
  logic                w_is_pm;
  logic [HOUR12_W-1:0] w_hour12;

  assign w_in_range = (hour24 <= HOUR24_W'(HOURS_PER_DAY - 1));
  assign w_is_pm    = (hour24 >= HOUR24_W'(HALF_DAY)) ? PM : AM;

  // Noon passes through unchanged; only 13-23 fold down by a half day.
  always_comb begin
    // NOTE: default first so every path assigns w_hour12 and no latch is inferred.
    w_hour12 = HOUR12_W'(hour24);
    if (hour24 == '0) begin
      w_hour12 = MIDNIGHT_HOUR;
    end else if (hour24 > HOUR24_W'(HALF_DAY)) begin
      w_hour12 = HOUR12_W'(hour24 - HOUR24_W'(HALF_DAY));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nam_pm    <= AM;
      r_hour12    <= MIDNIGHT_HOUR;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      r_err       <= in_valid & ~w_in_range;
      if (in_valid && w_in_range) begin
        r_nam_pm <= w_is_pm;
        r_hour12 <= w_hour12;
      end
    end
  end

  assign nAM_PM    = r_nam_pm;
  assign hour12    = r_hour12;
  assign out_valid = r_out_valid;
  assign err       = r_err;

`ifdef H24TOH12_BCD_EN
  localparam logic [HOUR12_W:0] MIDNIGHT_BCD = bin_to_bcd(MIDNIGHT_HOUR);

  logic       w_tens;
  logic [3:0] w_ones;
  logic       r_tens;
  logic [3:0] r_ones;

  h12_bcd_split u_bcd_split (
    .i_bin  (w_hour12),
    .o_tens (w_tens),
    .o_ones (w_ones)
  );

  // Digits load under the same condition as hour12 so they can never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tens <= MIDNIGHT_BCD[HOUR12_W];
      r_ones <= MIDNIGHT_BCD[HOUR12_W-1:0];
    end else if (in_valid && w_in_range) begin
      r_tens <= w_tens;
      r_ones <= w_ones;
    end
  end

  assign hour12_tens = r_tens;
  assign hour12_ones = r_ones;
`endif

endmodule

// File: tb/tb_h24_to_h12.sv
// Directed bench for h24_to_h12: two instances (MIDNIGHT_12 = 1 and 0) checked against a behavioural model.
module tb_h24_to_h12;

  logic       clk;
  logic       rst;
  logic [4:0] hour24;
  logic       in_valid;

  logic       a_pm, b_pm, a_ov, b_ov, a_err, b_err;
  logic [3:0] a_h12, b_h12;
`ifdef H24TOH12_BCD_EN
  logic       a_tens, b_tens;
  logic [3:0] a_ones, b_ones;
`endif

  h24_to_h12 #(.MIDNIGHT_12(1'b1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .hour24    (hour24),
    .in_valid  (in_valid),
    .nAM_PM    (a_pm),
    .hour12    (a_h12),
    .out_valid (a_ov),
    .err       (a_err)
`ifdef H24TOH12_BCD_EN
    ,
    .hour12_tens (a_tens),
    .hour12_ones (a_ones)
`endif
  );

  h24_to_h12 #(.MIDNIGHT_12(1'b0)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .hour24    (hour24),
    .in_valid  (in_valid),
    .nAM_PM    (b_pm),
    .hour12    (b_h12),
    .out_valid (b_ov),
    .err       (b_err)
`ifdef H24TOH12_BCD_EN
    ,
    .hour12_tens (b_tens),
    .hour12_ones (b_ones)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: index 0 = MIDNIGHT_12=1 instance, index 1 = MIDNIGHT_12=0 instance.
  int m_h12 [2];
  int m_pm;
  int m_valid;
  int m_err;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: 12-hour clock face value is h mod 12, with 0 shown as 12 (or 0 at midnight when disabled).
  task automatic model_update(input logic r, input logic v, input int h);
    int m;
    if (r) begin
      m_valid = 0; m_err = 0; m_pm = 0;
      m_h12[0] = 12; m_h12[1] = 0;
    end else begin
      m_valid = v ? 1 : 0;
      m_err   = (v && h > 23) ? 1 : 0;
      if (v && h <= 23) begin
        m        = h % 12;
        m_pm     = (h >= 12) ? 1 : 0;
        m_h12[0] = (m == 0) ? 12 : m;
        m_h12[1] = (h == 0) ? 0 : ((m == 0) ? 12 : m);
      end
    end
  endtask

  task automatic compare_all();
    check("a.hour12",    int'(a_h12), m_h12[0]);
    check("a.nAM_PM",    int'(a_pm),  m_pm);
    check("a.out_valid", int'(a_ov),  m_valid);
    check("a.err",       int'(a_err), m_err);
    check("b.hour12",    int'(b_h12), m_h12[1]);
    check("b.nAM_PM",    int'(b_pm),  m_pm);
    check("b.out_valid", int'(b_ov),  m_valid);
    check("b.err",       int'(b_err), m_err);
`ifdef H24TOH12_BCD_EN
    check("a.tens", int'(a_tens), m_h12[0] / 10);
    check("a.ones", int'(a_ones), m_h12[0] % 10);
    check("b.tens", int'(b_tens), m_h12[1] / 10);
    check("b.ones", int'(b_ones), m_h12[1] % 10);
`endif
  endtask

  // One clock: drive, let the edge happen, advance the model, compare on the falling edge.
  task automatic step(input logic r, input logic v, input int h);
    rst      = r;
    in_valid = v;
    hour24   = 5'(h);
    @(posedge clk);
    model_update(r, v, h);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; hour24 = '0;
    m_h12[0] = 0; m_h12[1] = 0; m_pm = 0; m_valid = 0; m_err = 0;
    @(negedge clk);

    // Reset for two cycles.
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    check("rst.a.hour12", int'(a_h12), 12);
    check("rst.b.hour12", int'(b_h12), 0);
    check("rst.nAM_PM",   int'(a_pm),  0);
    check("rst.out_valid", int'(a_ov), 0);
    check("rst.err",      int'(a_err), 0);

    // Full back-to-back sweep 0..23 with literal pins on the key hours.
    for (int h = 0; h < 24; h++) begin
      step(1'b0, 1'b1, h);
      case (h)
        0:  begin check("h0.a",  int'(a_h12), 12); check("h0.b", int'(b_h12), 0); check("h0.pm", int'(a_pm), 0); end
        1:  begin check("h1",    int'(a_h12), 1);  check("h1.pm",  int'(a_pm), 0); end
        11: begin check("h11",   int'(a_h12), 11); check("h11.pm", int'(a_pm), 0); end
        12: begin check("h12.a", int'(a_h12), 12); check("h12.b", int'(b_h12), 12); check("h12.pm", int'(a_pm), 1); end
        13: begin check("h13",   int'(a_h12), 1);  check("h13.pm", int'(a_pm), 1); end
        23: begin check("h23",   int'(a_h12), 11); check("h23.pm", int'(a_pm), 1); check("h23.ov", int'(a_ov), 1); end
        default: ;
      endcase
    end

    // Out of range: 15 then 24 then 31 -> 3 PM held with err.
    step(1'b0, 1'b1, 15);
    check("h15", int'(a_h12), 3);
    step(1'b0, 1'b1, 24);
    check("h24.err", int'(a_err), 1);
    check("h24.ov",  int'(a_ov),  1);
    check("h24.hold", int'(a_h12), 3);
    step(1'b0, 1'b1, 31);
    check("h31.err",  int'(a_err), 1);
    check("h31.hold", int'(a_h12), 3);
    check("h31.pm",   int'(a_pm),  1);

    // Gapped input after 18.
    step(1'b0, 1'b1, 18);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 5);
      check("gap.ov",   int'(a_ov),  0);
      check("gap.err",  int'(a_err), 0);
      check("gap.hold", int'(a_h12), 6);
      check("gap.pm",   int'(a_pm),  1);
    end

    // Reset wins over a concurrent sample.
    step(1'b1, 1'b1, 20);
    check("rstpri.h12", int'(a_h12), 12);
    check("rstpri.pm",  int'(a_pm),  0);
    check("rstpri.ov",  int'(a_ov),  0);

    // Midnight-as-zero instance and BCD digits.
    step(1'b0, 1'b1, 0);
    check("mid0.b", int'(b_h12), 0);
    step(1'b0, 1'b1, 22);
    check("h22.b",  int'(b_h12), 10);
    check("h22.pm", int'(b_pm),  1);
`ifdef H24TOH12_BCD_EN
    check("h22.tens", int'(b_tens), 1);
    check("h22.ones", int'(b_ones), 0);
`endif

    // Mixed stream with a mid-stream reset.
    step(1'b0, 1'b1, 9);
    step(1'b0, 1'b1, 27);
    step(1'b0, 1'b1, 12);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 17);
    check("h17", int'(a_h12), 5);
    step(1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
